// File: rtl/dm_bytelane.sv
// ============================================================================
// Module      : dm_bytelane
// Description : Byte-addressed data memory with byte/half/word access, sign or
//               zero extension, a registered read with write forwarding, and a
//               sequential clear FSM. Define DM_PRELOAD_EN to preload the
//               branch/loop test data (word 20 = 10, word 21 = 3) during clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_bytelane #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_busy,
    input  logic                wr,
    input  logic [ADDR_W+1:0]   waddr,
    input  logic [1:0]          wsize,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                rd,
    input  logic [ADDR_W+1:0]   raddr,
    input  logic [1:0]          rsize,
    input  logic                rsigned,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                misalign
);

    localparam int         DEPTH      = 2 ** ADDR_W;
    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;
`ifdef DM_PRELOAD_EN
    localparam bit              c_PRELOAD_OK = (DEPTH > 21);
    localparam logic [ADDR_W-1:0] c_PRE_IDX0 = ADDR_W'(20);
    localparam logic [ADDR_W-1:0] c_PRE_IDX1 = ADDR_W'(21);
`endif

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_misalign;

    logic              w_ready;
    logic              w_clr;
    logic              w_wmis;
    logic              w_rmis;
    logic              w_wacc;
    logic              w_racc;
    logic [ADDR_W-1:0] w_widx;
    logic [ADDR_W-1:0] w_ridx;
    logic [3:0]        w_wbe;
    logic [31:0]       w_wrep;
    logic [31:0]       w_wold;
    logic [31:0]       w_wmerged;
    logic [31:0]       w_rword;
    logic [31:0]       w_rshift;
    logic [31:0]       w_rext;

    function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            2'b10:   return |a;
            default: return 1'b1;
        endcase
    endfunction

    assign w_ready = rst && (r_state == c_ST_READY);
    assign w_clr   = rst && (r_state == c_ST_CLEAR);
    assign w_widx  = waddr[ADDR_W+1:2];
    assign w_ridx  = raddr[ADDR_W+1:2];
    assign w_wmis  = f_misaligned(wsize, waddr[1:0]);
    assign w_rmis  = f_misaligned(rsize, raddr[1:0]);
    assign w_wacc  = w_ready && wr && !w_wmis;
    assign w_racc  = w_ready && rd;
    assign w_wold  = r_mem[w_widx];

    // Replicate the store data across lanes, then pick lanes by byte enable.
    always_comb begin
        w_wbe  = 4'b0000;
        w_wrep = wdata;
        case (wsize)
            2'b00: begin
                w_wbe  = 4'b0001 << waddr[1:0];
                w_wrep = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_wbe  = waddr[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{wdata[15:0]}};
            end
            2'b10:   w_wbe = 4'b1111;
            default: w_wbe = 4'b0000;
        endcase
        w_wmerged = w_wold;
        for (int k = 0; k < 4; k++) begin
            if (w_wbe[k]) begin
                w_wmerged[8*k +: 8] = w_wrep[8*k +: 8];
            end
        end
    end

    // A same-word store in the same cycle is visible to the load.
    assign w_rword  = (w_wacc && (w_widx == w_ridx)) ? w_wmerged : r_mem[w_ridx];
    assign w_rshift = w_rword >> {raddr[1:0], 3'b000};

    always_comb begin
        w_rext = '0;
        if (!w_rmis) begin
            case (rsize)
                2'b00:   w_rext = {{24{rsigned & w_rshift[7]}}, w_rshift[7:0]};
                2'b01:   w_rext = {{16{rsigned & w_rshift[15]}}, w_rshift[15:0]};
                2'b10:   w_rext = w_rword;
                default: w_rext = '0;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == c_ST_CLEAR) && (r_clr_ptr == '1)) begin
            w_state_nxt = c_ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_ST_CLEAR;
            r_clr_ptr  <= '0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
            r_rvalid   <= w_racc;
            r_misalign <= (w_racc && w_rmis) || (w_ready && wr && w_wmis);
            if (w_racc) begin
                r_rdata <= w_rext;
            end
        end
    end

    // Storage has no reset; it is only written by the clear walk or a store.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_mem[r_clr_ptr] <= '0;
`ifdef DM_PRELOAD_EN
            if (c_PRELOAD_OK && (r_clr_ptr == '1)) begin
                r_mem[c_PRE_IDX0] <= 32'd10;
                r_mem[c_PRE_IDX1] <= 32'h3;
            end
`endif
        end else if (w_wacc) begin
            r_mem[w_widx] <= w_wmerged;
        end
    end

    assign init_busy = (r_state == c_ST_CLEAR);
    assign rdata     = r_rdata;
    assign rvalid    = r_rvalid;
    assign misalign  = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_dm_bytelane.sv
// ============================================================================
// Module      : tb_dm_bytelane
// Description : Directed vector bench for dm_bytelane (clear, loads, stores,
//               forwarding, misalignment, reset during clear).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_bytelane;

    localparam int ADDR_W = 7;
    localparam int AW     = ADDR_W + 2;
`ifdef DM_PRELOAD_EN
    localparam logic [31:0] c_PRE = 32'd10;
`else
    localparam logic [31:0] c_PRE = 32'd0;
`endif

    typedef struct {
        logic          wr;
        logic [AW-1:0] waddr;
        logic [1:0]    wsize;
        logic [31:0]   wdata;
        logic          rd;
        logic [AW-1:0] raddr;
        logic [1:0]    rsize;
        logic          rsigned;
        logic [31:0]   exp_rdata;
        logic          exp_rvalid;
        logic          exp_mis;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_busy;
    logic          wr;
    logic [AW-1:0] waddr;
    logic [1:0]    wsize;
    logic [31:0]   wdata;
    logic          rd;
    logic [AW-1:0] raddr;
    logic [1:0]    rsize;
    logic          rsigned;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          misalign;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];
    vec_t post[$];

    always #5 clk = ~clk;

    dm_bytelane #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .wr        (wr),
        .waddr     (waddr),
        .wsize     (wsize),
        .wdata     (wdata),
        .rd        (rd),
        .raddr     (raddr),
        .rsize     (rsize),
        .rsigned   (rsigned),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .misalign  (misalign)
    );

    function automatic vec_t mk(input logic w, input int wa, input logic [1:0] ws,
                                input logic [31:0] wd, input logic r, input int ra,
                                input logic [1:0] rs, input logic sg,
                                input logic [31:0] erd, input logic erv, input logic em);
        vec_t v;
        v.wr = w;  v.waddr = AW'(wa); v.wsize = ws; v.wdata = wd;
        v.rd = r;  v.raddr = AW'(ra); v.rsize = rs; v.rsigned = sg;
        v.exp_rdata = erd; v.exp_rvalid = erv; v.exp_mis = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr = 1'b0; waddr = '0; wsize = 2'b00; wdata = '0;
        rd = 1'b0; raddr = '0; rsize = 2'b00; rsigned = 1'b0;
    endtask

    task automatic apply(input string name, input vec_t v);
        @(negedge clk);
        wr = v.wr; waddr = v.waddr; wsize = v.wsize; wdata = v.wdata;
        rd = v.rd; raddr = v.raddr; rsize = v.rsize; rsigned = v.rsigned;
        @(posedge clk);
        #1;
        check(name, {rdata, rvalid, misalign}, {v.exp_rdata, v.exp_rvalid, v.exp_mis});
    endtask

    // Counts edges from reset release until init_busy drops, checking that
    // any probe traffic driven meanwhile produces no response.
    task automatic count_clear(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            check("busy_ignore", {32'd0, rvalid, misalign}, 34'd0);
        end while (init_busy && n < 1000);
    endtask

    initial begin
        int n;

        // wr rd: waddr wsize wdata | raddr rsize signed | rdata rvalid mis
        vecs.push_back(mk(0, 0, 2, 0, 1, 'h50, 2, 0, c_PRE, 1, 0));
        vecs.push_back(mk(1, 'h04, 2, 32'h80FF7F01, 0, 0, 0, 0, c_PRE, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h07, 0, 1, 32'hFFFFFF80, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h07, 0, 0, 32'h00000080, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h04, 1, 1, 32'h00007F01, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h06, 1, 1, 32'hFFFF80FF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h06, 1, 0, 32'h000080FF, 1, 0));
        vecs.push_back(mk(1, 'h08, 2, 32'h11223344, 0, 0, 0, 0, 32'h000080FF, 0, 0));
        vecs.push_back(mk(1, 'h09, 0, 32'h000000AA, 0, 0, 0, 0, 32'h000080FF, 0, 0));
        vecs.push_back(mk(1, 'h0A, 1, 32'h0000BEEF, 0, 0, 0, 0, 32'h000080FF, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h08, 2, 0, 32'hBEEFAA44, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h0A, 0, 1, 32'hFFFFFFEF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h0A, 1, 0, 32'h0000BEEF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h08, 2, 1, 32'hBEEFAA44, 1, 0));
        vecs.push_back(mk(1, 'h0E, 0, 32'h0000005A, 1, 'h0C, 2, 0, 32'h005A0000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h0C, 2, 0, 32'h005A0000, 1, 0));
        vecs.push_back(mk(1, 'h05, 1, 32'h0000FFFF, 0, 0, 0, 0, 32'h005A0000, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h04, 2, 0, 32'h80FF7F01, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h02, 2, 0, 32'h00000000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0));
        vecs.push_back(mk(1, 'h02, 2, 32'hFFFFFFFF, 1, 'h01, 1, 1, 32'h00000000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 2, 0, 32'h00000000, 1, 0));
        vecs.push_back(mk(1, 'h10, 3, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h00000000, 0, 1));
        vecs.push_back(mk(1, 'h12, 1, 32'h00008001, 1, 'h12, 1, 1, 32'hFFFF8001, 1, 0));
        vecs.push_back(mk(1, 'h11, 1, 32'h0000FFFF, 1, 'h10, 2, 0, 32'h80010000, 1, 1));
        vecs.push_back(mk(1, 'h14, 2, 32'h12345678, 1, 'h18, 2, 0, 32'h00000000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h14, 2, 0, 32'h12345678, 1, 0));
        vecs.push_back(mk(1, 'h1FC, 2, 32'hDEADBEEF, 0, 0, 0, 0, 32'h12345678, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h1FC, 2, 0, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h1FF, 0, 1, 32'hFFFFFFDE, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h1FD, 0, 0, 32'h000000BE, 1, 0));
        vecs.push_back(mk(1, 'h00, 2, 32'hCAFEF00D, 0, 0, 0, 0, 32'h000000BE, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 2, 0, 32'hCAFEF00D, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 1, 1, 32'hFFFFF00D, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 'h00, 0, 1, 32'h0000000D, 1, 0));

        post.push_back(mk(0, 0, 0, 0, 1, 'h00, 2, 0, 32'h00000000, 1, 0));
        post.push_back(mk(0, 0, 0, 0, 1, 'h50, 2, 0, c_PRE, 1, 0));
        post.push_back(mk(0, 0, 0, 0, 1, 'h1FC, 2, 0, 32'h00000000, 1, 0));

        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {rdata, rvalid, misalign}, 34'd0);
        check("reset_busy", {33'd0, init_busy}, 34'd1);

        @(negedge clk);
        rst = 1'b1;
        count_clear(n);
        check("clear_cycles", 34'(n), 34'd128);

        for (int i = 0; i < vecs.size(); i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset during clear: 40 cycles in, pull rst low again.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        wr = 1'b1; waddr = '0; wsize = 2'b10; wdata = 32'hFFFFFFFF;
        rd = 1'b1; raddr = '0; rsize = 2'b10;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check("midclear_busy", {31'd0, init_busy, rvalid, misalign}, 34'b100);
        end
        @(negedge clk);
        rst = 1'b0;
        wsize = 2'b11; raddr = AW'(2);
        repeat (2) @(posedge clk);
        #1;
        check("midclear_reset", {rdata, rvalid, misalign}, 34'd0);
        check("midclear_reset_busy", {33'd0, init_busy}, 34'd1);
        @(negedge clk);
        rst = 1'b1;
        count_clear(n);
        check("reclear_cycles", 34'(n), 34'd128);
        @(negedge clk);
        idle();

        for (int i = 0; i < post.size(); i++) begin
            apply($sformatf("post%0d", i), post[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
